// File: rtl/hack_boot_loader.sv
// hack_boot_loader: byte-serial, length-prefixed loader for the Hack instruction ROM; holds the CPU in reset until loaded.
// Defining HACK_BOOT_CHECKSUM_EN adds a trailing 16-bit word-sum check (SUM_HI/SUM_LO) before release.
module hack_boot_loader #(
  parameter int ADDR_W    = 15,
  parameter bit AUTO_BOOT = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              boot_start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_data,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] LEN_HI  = 4'd1;
  localparam logic [3:0] LEN_LO  = 4'd2;
  localparam logic [3:0] DATA_HI = 4'd3;
  localparam logic [3:0] DATA_LO = 4'd4;
  localparam logic [3:0] RUN     = 4'd5;
  localparam logic [3:0] ERROR   = 4'd6;
`ifdef HACK_BOOT_CHECKSUM_EN
  localparam logic [3:0] SUM_HI  = 4'd7;
  localparam logic [3:0] SUM_LO  = 4'd8;
  localparam logic [3:0] LOAD_END = SUM_HI;
`else
  localparam logic [3:0] LOAD_END = RUN;
`endif

  localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

  logic [3:0]      state;
  logic [ADDR_W:0] cnt;
  logic [15:0]     len_q;
  logic [7:0]      hi_q;
  logic            receiving;
  logic            take;
  logic            start;
`ifdef HACK_BOOT_CHECKSUM_EN
  logic [15:0]     sum_q;
`endif

  // N == DEPTH is still legal: the counter carries one extra bit for it.
  function automatic logic len_over(input logic [15:0] n);
    return {16'd0, n} > DEPTH;
  endfunction

  function automatic logic last_word(input logic [ADDR_W:0] c, input logic [15:0] n);
    return (32'(c) + 32'd1) == {16'd0, n};
  endfunction

  always_comb begin
    receiving = 1'b0;
    case (state)
      LEN_HI, LEN_LO, DATA_HI, DATA_LO: receiving = 1'b1;
`ifdef HACK_BOOT_CHECKSUM_EN
      SUM_HI, SUM_LO:                   receiving = 1'b1;
`endif
      default:                          receiving = 1'b0;
    endcase
  end

  always_comb begin
    start = 1'b0;
    case (state)
      IDLE:       start = AUTO_BOOT || boot_start;
      RUN, ERROR: start = boot_start;
      default:    start = 1'b0;
    endcase
  end

  assign take      = rx_valid && receiving;
  assign rx_ready  = receiving;
  assign busy      = receiving;
  assign cpu_reset = (state != RUN);
  assign done      = (state == RUN);
  assign err       = (state == ERROR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      len_q    <= '0;
      hi_q     <= '0;
      rom_we   <= 1'b0;
      rom_addr <= '0;
      rom_data <= '0;
`ifdef HACK_BOOT_CHECKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      rom_we <= 1'b0;
      if (start) begin
        state <= LEN_HI;
        cnt   <= '0;
`ifdef HACK_BOOT_CHECKSUM_EN
        sum_q <= '0;
`endif
      end else if (take) begin
        case (state)
          LEN_HI: begin
            len_q[15:8] <= rx_data;
            state       <= LEN_LO;
          end
          LEN_LO: begin
            len_q[7:0] <= rx_data;
            if ({len_q[15:8], rx_data} == 16'd0)      state <= LOAD_END;
            else if (len_over({len_q[15:8], rx_data})) state <= ERROR;
            else                                        state <= DATA_HI;
          end
          DATA_HI: begin
            hi_q  <= rx_data;
            state <= DATA_LO;
          end
          DATA_LO: begin
            rom_we   <= 1'b1;
            rom_addr <= cnt[ADDR_W-1:0];
            rom_data <= {hi_q, rx_data};
            cnt      <= cnt + 1'b1;
`ifdef HACK_BOOT_CHECKSUM_EN
            sum_q    <= sum_q + {hi_q, rx_data};
`endif
            state    <= last_word(cnt, len_q) ? LOAD_END : DATA_HI;
          end
`ifdef HACK_BOOT_CHECKSUM_EN
          SUM_HI: begin
            hi_q  <= rx_data;
            state <= SUM_LO;
          end
          SUM_LO: begin
            state <= ({hi_q, rx_data} == sum_q) ? RUN : ERROR;
          end
`endif
          default: state <= state;
        endcase
      end
    end
  end

endmodule
